// File: rtl/cpu_register_pkg.sv
// cpu_register_pkg
//   Shared sizing and types for the cpu_register general-purpose register file.
//   DATA_W   : default register width
//   ADDR_W   : default address width
//   NUM_REGS : register count, 2**ADDR_W
//   data_t / addr_t : convenience types at the default sizes
package cpu_register_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/cpu_register_read_mux.sv
// cpu_register_read_mux
//   One combinational read port of the register file: selects one of the
//   2**ADDR_W stored words. An optional same-cycle bypass returns the write
//   data instead when a write to the selected register is pending.
// Ports:
//   regs      : all stored register contents
//   sel       : read address
//   bypass_en : a qualified write is pending this cycle (0 disables bypass)
//   wr_addr   : pending write address
//   wr_data   : pending write data
//   rd_data   : selected word
module cpu_register_read_mux
  import cpu_register_pkg::*;
#(
  parameter int DATA_W = cpu_register_pkg::DATA_W,
  parameter int ADDR_W = cpu_register_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] sel,
  input  logic              bypass_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = regs[sel];
    if (bypass_en && (sel == wr_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/cpu_register.sv
// cpu_register
//   16 x 8 flip-flop register file with two combinational read ports (A, B)
//   and one synchronous write port. Reset is synchronous, active-high, and
//   wins over a concurrent write.
//   Optional build macro WRITE_BYPASS_EN: when defined, a read of the register
//   being written in the same cycle returns din instead of the stored value.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous active-high clear of all registers
//   addr_a   : read address, port A
//   addr_b   : read address, port B
//   addr_wr  : write address
//   write_en : write strobe, sampled at the rising edge
//   din      : write data
//   out_a    : contents of register addr_a
//   out_b    : contents of register addr_b
module cpu_register
  import cpu_register_pkg::*;
#(
  parameter int DATA_W = cpu_register_pkg::DATA_W,
  parameter int ADDR_W = cpu_register_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic              write_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              bypass_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[addr_wr] <= din;
    end
  end

  // Bypass is only legal for a write that will actually land, so a write
  // masked by reset must not leak onto the read ports.
`ifdef WRITE_BYPASS_EN
  assign bypass_en = write_en & ~reset;
`else
  assign bypass_en = 1'b0;
`endif

  cpu_register_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux_a (
    .regs      (regs),
    .sel       (addr_a),
    .bypass_en (bypass_en),
    .wr_addr   (addr_wr),
    .wr_data   (din),
    .rd_data   (out_a)
  );

  cpu_register_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux_b (
    .regs      (regs),
    .sel       (addr_b),
    .bypass_en (bypass_en),
    .wr_addr   (addr_wr),
    .wr_data   (din),
    .rd_data   (out_b)
  );

endmodule

// File: tb/tb_cpu_register.sv
module tb_cpu_register;
  import cpu_register_pkg::*;

  logic  clock;
  logic  reset;
  addr_t addr_a;
  addr_t addr_b;
  addr_t addr_wr;
  logic  write_en;
  data_t din;
  data_t out_a;
  data_t out_b;

  cpu_register dut (
    .clock    (clock),
    .reset    (reset),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .addr_wr  (addr_wr),
    .write_en (write_en),
    .din      (din),
    .out_a    (out_a),
    .out_b    (out_b)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    data_t exp_a;
    data_t exp_b;
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  data_t mdl [NUM_REGS];
  int    total = 0;
  int    bad   = 0;
  bit    bypass_build;

  // Monitor: each queued expectation is checked 1 time unit after it appears.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() > 0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (out_a !== e.exp_a || out_b !== e.exp_b) begin
        bad++;
        $display("FAIL %s: out_a=%h out_b=%h, expected out_a=%h out_b=%h",
                 e.tag, out_a, out_b, e.exp_a, e.exp_b);
      end
    end
  end

  // Expected read value of one port from the architectural model, including
  // a same-cycle bypass of a pending write in the bypass build.
  function automatic data_t expect_rd(addr_t a);
    if (bypass_build && write_en && !reset && a == addr_wr) return din;
    return mdl[a];
  endfunction

  task automatic probe(input addr_t a, input addr_t b, input string tag);
    exp_t e;
    addr_a = a;
    addr_b = b;
    e.exp_a = expect_rd(a);
    e.exp_b = expect_rd(b);
    e.tag   = tag;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic read(input addr_t a, input addr_t b, input string tag);
    @(negedge clock);
    probe(a, b, tag);
  endtask

  // Let the pending inputs take effect at the next rising edge and mirror
  // that edge in the model.
  task automatic apply_edge();
    @(posedge clock);
    if (reset) begin
      foreach (mdl[i]) mdl[i] = '0;
    end else if (write_en) begin
      mdl[addr_wr] = din;
    end
    #1;
    write_en = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic step(input logic we, input addr_t wa, input data_t d, input logic rst);
    @(negedge clock);
    write_en = we;
    addr_wr  = wa;
    din      = d;
    reset    = rst;
    apply_edge();
  endtask

  initial begin
`ifdef WRITE_BYPASS_EN
    bypass_build = 1'b1;
`else
    bypass_build = 1'b0;
`endif
    reset    = 1'b0;
    write_en = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    addr_wr  = '0;
    din      = '0;

    step(1'b0, 4'd0, 8'h00, 1'b1);

    // Reset clears everything written before it.
    for (int i = 0; i < NUM_REGS; i++) step(1'b1, addr_t'(i), data_t'($urandom_range(1, 255)), 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b1);
    for (int i = 0; i < NUM_REGS; i++) read(addr_t'(i), addr_t'(NUM_REGS - 1 - i), "reset_sweep");

    // Basic write then read.
    step(1'b1, 4'd0, 8'h91, 1'b0);
    step(1'b1, 4'd1, 8'h97, 1'b0);
    read(4'd0, 4'd1, "basic_rw");

    // Disabled writes change nothing.
    repeat (3) step(1'b0, 4'd4, 8'hFF, 1'b0);
    read(4'd4, 4'd0, "write_disabled");
    read(4'd1, 4'd1, "write_disabled_hold");

    // Read ports follow address changes with no clock edge.
    @(negedge clock);
    probe(4'd0, 4'd1, "comb_read_0");
    probe(4'd4, 4'd1, "comb_read_4");
    probe(4'd0, 4'd4, "comb_read_back");

    // Same-cycle read of the register being written.
    @(negedge clock);
    write_en = 1'b1;
    addr_wr  = 4'd2;
    din      = 8'h5A;
    probe(4'd2, 4'd2, "raw_before_edge");
    apply_edge();
    read(4'd2, 4'd2, "raw_after_edge");

    // Reset wins over a concurrent write; the bypass must stay quiet too.
    @(negedge clock);
    write_en = 1'b1;
    addr_wr  = 4'd3;
    din      = 8'hAA;
    reset    = 1'b1;
    probe(4'd3, 4'd0, "rst_vs_write_before");
    apply_edge();
    read(4'd3, 4'd3, "rst_vs_write");

    // Full write/readback.
    for (int i = 0; i < NUM_REGS; i++) step(1'b1, addr_t'(i), data_t'(8'h10 + i), 1'b0);
    for (int i = 0; i < NUM_REGS; i++) read(addr_t'(i), addr_t'(i), "full_readback");

    // Randomised traffic: probes taken while the write is pending, before its edge.
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      write_en = ($urandom_range(0, 2) != 0);
      addr_wr  = addr_t'($urandom_range(0, NUM_REGS - 1));
      din      = data_t'($urandom);
      reset    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) == 0) probe(addr_wr, addr_t'($urandom_range(0, NUM_REGS - 1)), "rand_raw");
      else probe(addr_t'($urandom_range(0, NUM_REGS - 1)), addr_t'($urandom_range(0, NUM_REGS - 1)), "rand");
      apply_edge();
    end

    for (int i = 0; i < NUM_REGS; i++) read(addr_t'(i), addr_t'($urandom_range(0, NUM_REGS - 1)), "final_sweep");

    repeat (20) begin
      if (exp_q.size() != 0) #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
